memory_access_unit: RTL and testbench



---
 rtl/cpu_mem_pkg.sv | 23 ++
 rtl/byte_lane_align.sv | 25 ++
 rtl/memory_access_unit.sv | 132 +++++++++++++
 tb/tb_memory_access_unit.sv | 224 ++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_mem_pkg.sv
// rtl/cpu_mem_pkg.sv - shared types, constants and helpers for the memory access unit
//
// Contents:
//   mau_state_t      FSM state encoding (IDLE, REQ, DONE)
//   BYTE_LANES       number of byte lanes in a data word
//   WORD_ALIGN_BITS  address bits that select a byte inside a word
//   byte_be()        one-hot byte-enable mask for a byte offset
package cpu_mem_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    DONE = 2'd2
  } mau_state_t;

  localparam int BYTE_LANES      = 4;
  localparam int WORD_ALIGN_BITS = 2;

  function automatic logic [BYTE_LANES-1:0] byte_be(input logic [WORD_ALIGN_BITS-1:0] offset);
    return BYTE_LANES'(1) << offset;
  endfunction

endpackage

// File: rtl/byte_lane_align.sv
// rtl/byte_lane_align.sv - combinational load lane select and zero extension
//
// Ports:
//   word     in   DATA_W  raw read word from memory
//   offset   in   2       byte offset within the word (little-endian lanes)
//   is_byte  in   1       1 = byte load, 0 = word load
//   data     out  DATA_W  aligned load result
module byte_lane_align
  import cpu_mem_pkg::*;
#(
  parameter int DATA_W = 32
) (
  input  logic [DATA_W-1:0]          word,
  input  logic [WORD_ALIGN_BITS-1:0] offset,
  input  logic                       is_byte,
  output logic [DATA_W-1:0]          data
);

  logic [7:0] lane;

  // Lane n occupies bits [8n+7:8n].
  assign lane = word[{offset, 3'b000} +: 8];
  assign data = is_byte ? {{(DATA_W-8){1'b0}}, lane} : word;

endmodule

// File: rtl/memory_access_unit.sv
// rtl/memory_access_unit.sv - memory-stage data memory controller with pipeline stall
//
// Ports:
//   clock, reset                  rising-edge clock, async active-low reset
//   m_mem_read, m_mem_write       access request from EX/MEM (write wins)
//   m_mem_byte                    byte access (1) or word access (0)
//   m_alu_result, m_store_data    byte address and store data
//   m_stall                       freeze upstream pipeline while an access is in flight
//   m_load_data, m_load_valid     aligned load result and its one-cycle update pulse
//   m_misaligned                  word access with addr[1:0] != 0; access suppressed
//   mem_req/we/addr/wdata/be      request to variable-latency data memory, held until ack
//   mem_ack, mem_rdata            memory completion and read word
module memory_access_unit
  import cpu_mem_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 32
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  m_mem_read,
  input  logic                  m_mem_write,
  input  logic                  m_mem_byte,
  input  logic [ADDR_W-1:0]     m_alu_result,
  input  logic [DATA_W-1:0]     m_store_data,
  output logic                  m_stall,
  output logic [DATA_W-1:0]     m_load_data,
  output logic                  m_load_valid,
  output logic                  m_misaligned,
  output logic                  mem_req,
  output logic                  mem_we,
  output logic [ADDR_W-1:0]     mem_addr,
  output logic [DATA_W-1:0]     mem_wdata,
  output logic [BYTE_LANES-1:0] mem_be,
  input  logic                  mem_ack,
  input  logic [DATA_W-1:0]     mem_rdata
);

  mau_state_t                 state_q, state_d;
  logic [WORD_ALIGN_BITS-1:0] offset_q;
  logic                       byte_q;
  logic                       capture;
  logic                       load_update;
  logic                       pending;
  logic                       bad_align;
  logic [DATA_W-1:0]          aligned_rdata;

  assign pending   = m_mem_read | m_mem_write;
  assign bad_align = !m_mem_byte && (m_alu_result[WORD_ALIGN_BITS-1:0] != '0);

  byte_lane_align #(.DATA_W(DATA_W)) u_align (
    .word    (mem_rdata),
    .offset  (offset_q),
    .is_byte (byte_q),
    .data    (aligned_rdata)
  );

  // Next state and outputs. The whole decode is gated by reset so that the
  // combinational stall/misaligned outputs also drop while reset is held,
  // even if the pipeline keeps presenting a request.
  always_comb begin
    state_d      = state_q;
    m_stall      = 1'b0;
    m_misaligned = 1'b0;
    mem_req      = 1'b0;
    m_load_valid = 1'b0;
    capture      = 1'b0;
    load_update  = 1'b0;
    if (reset) begin
      case (state_q)
        IDLE: begin
          if (pending) begin
            if (bad_align) begin
              m_misaligned = 1'b1;
            end else begin
              m_stall = 1'b1;
              capture = 1'b1;
              state_d = REQ;
            end
          end
        end
        REQ: begin
          mem_req = 1'b1;
          m_stall = 1'b1;
          if (mem_ack) begin
            state_d     = DONE;
            load_update = !mem_we;
          end
        end
        DONE: begin
          // Stall is released here so the pipeline moves past this request
          // at the coming edge; it is therefore never re-issued from IDLE.
          m_load_valid = !mem_we;
          state_d      = IDLE;
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q     <= IDLE;
      mem_we      <= 1'b0;
      mem_addr    <= '0;
      mem_wdata   <= '0;
      mem_be      <= '0;
      offset_q    <= '0;
      byte_q      <= 1'b0;
      m_load_data <= '0;
    end else begin
      state_q <= state_d;
      if (capture) begin
        mem_addr <= {m_alu_result[ADDR_W-1:WORD_ALIGN_BITS], {WORD_ALIGN_BITS{1'b0}}};
        mem_we   <= m_mem_write;
        offset_q <= m_alu_result[WORD_ALIGN_BITS-1:0];
        byte_q   <= m_mem_byte;
        if (m_mem_byte) begin
          mem_be    <= byte_be(m_alu_result[WORD_ALIGN_BITS-1:0]);
          mem_wdata <= {BYTE_LANES{m_store_data[7:0]}};
        end else begin
          mem_be    <= '1;
          mem_wdata <= m_store_data;
        end
      end
      if (load_update) begin
        m_load_data <= aligned_rdata;
      end
    end
  end

endmodule

// File: tb/tb_memory_access_unit.sv
// tb/tb_memory_access_unit.sv - self-checking bench for memory_access_unit
module tb_memory_access_unit;

  logic        clock;
  logic        reset;
  logic        m_mem_read;
  logic        m_mem_write;
  logic        m_mem_byte;
  logic [31:0] m_alu_result;
  logic [31:0] m_store_data;
  logic        m_stall;
  logic [31:0] m_load_data;
  logic        m_load_valid;
  logic        m_misaligned;
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_be;
  logic        mem_ack;
  logic [31:0] mem_rdata;

  int n_checks;
  int n_fails;
  logic [31:0] model_load;

  memory_access_unit dut (
    .clock        (clock),
    .reset        (reset),
    .m_mem_read   (m_mem_read),
    .m_mem_write  (m_mem_write),
    .m_mem_byte   (m_mem_byte),
    .m_alu_result (m_alu_result),
    .m_store_data (m_store_data),
    .m_stall      (m_stall),
    .m_load_data  (m_load_data),
    .m_load_valid (m_load_valid),
    .m_misaligned (m_misaligned),
    .mem_req      (mem_req),
    .mem_we       (mem_we),
    .mem_addr     (mem_addr),
    .mem_wdata    (mem_wdata),
    .mem_be       (mem_be),
    .mem_ack      (mem_ack),
    .mem_rdata    (mem_rdata)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fails++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic drive_idle();
    m_mem_read   = 1'b0;
    m_mem_write  = 1'b0;
    m_mem_byte   = 1'b0;
    m_alu_result = $urandom;
    m_store_data = $urandom;
  endtask

  // One pipeline access: request presented in cycle 0, ack after lat REQ cycles.
  task automatic do_access(input logic rd, input logic wr, input logic bt,
                           input logic [31:0] addr, input logic [31:0] sdata,
                           input int lat, input logic [31:0] rdata);
    logic        is_store;
    logic [1:0]  off;
    logic [31:0] exp_addr, exp_wdata, exp_be;
    is_store  = wr;
    off       = addr[1:0];
    exp_addr  = addr & 32'hFFFF_FFFC;
    exp_be    = bt ? (32'd1 << off) : 32'hF;
    exp_wdata = bt ? ({24'd0, sdata[7:0]} * 32'h0101_0101) : sdata;

    @(posedge clock); #1;
    m_mem_read   = rd;
    m_mem_write  = wr;
    m_mem_byte   = bt;
    m_alu_result = addr;
    m_store_data = sdata;
    mem_ack      = 1'b0;
    @(negedge clock);
    if (!bt && off != 2'd0) begin
      check("misaligned_flag", {31'd0, m_misaligned}, 32'd1);
      check("misaligned_stall", {31'd0, m_stall}, 32'd0);
      check("misaligned_req", {31'd0, mem_req}, 32'd0);
      @(posedge clock); #1;
      drive_idle();
      @(negedge clock);
      check("misaligned_req_after", {31'd0, mem_req}, 32'd0);
      check("misaligned_load_data", m_load_data, model_load);
      return;
    end
    check("c0_stall", {31'd0, m_stall}, 32'd1);
    check("c0_req", {31'd0, mem_req}, 32'd0);
    check("c0_misaligned", {31'd0, m_misaligned}, 32'd0);
    for (int i = 1; i <= lat; i++) begin
      @(posedge clock); #1;
      mem_ack   = (i == lat);
      mem_rdata = (i == lat) ? rdata : $urandom;
      @(negedge clock);
      check("req_high", {31'd0, mem_req}, 32'd1);
      check("req_stall", {31'd0, m_stall}, 32'd1);
      check("req_addr", mem_addr, exp_addr);
      check("req_be", {28'd0, mem_be}, exp_be);
      check("req_we", {31'd0, mem_we}, {31'd0, is_store});
      if (is_store) check("req_wdata", mem_wdata, exp_wdata);
      check("req_no_valid", {31'd0, m_load_valid}, 32'd0);
    end
    if (!is_store) model_load = bt ? ((rdata >> (8 * off)) & 32'hFF) : rdata;
    @(posedge clock); #1;
    mem_ack   = 1'b0;
    mem_rdata = $urandom;
    @(negedge clock);
    check("done_stall", {31'd0, m_stall}, 32'd0);
    check("done_req", {31'd0, mem_req}, 32'd0);
    check("done_valid", {31'd0, m_load_valid}, {31'd0, !is_store});
    check("done_load_data", m_load_data, model_load);
    @(posedge clock); #1;
    drive_idle();
    @(negedge clock);
    check("idle_valid", {31'd0, m_load_valid}, 32'd0);
    check("idle_req", {31'd0, mem_req}, 32'd0);
    check("idle_stall", {31'd0, m_stall}, 32'd0);
  endtask

  initial begin
    n_checks   = 0;
    n_fails    = 0;
    model_load = 32'd0;
    reset      = 1'b0;
    mem_ack    = 1'b0;
    mem_rdata  = 32'd0;
    drive_idle();
    repeat (3) @(posedge clock);
    @(negedge clock);
    check("rst_req", {31'd0, mem_req}, 32'd0);
    check("rst_we", {31'd0, mem_we}, 32'd0);
    check("rst_addr", mem_addr, 32'd0);
    check("rst_wdata", mem_wdata, 32'd0);
    check("rst_be", {28'd0, mem_be}, 32'd0);
    check("rst_load_data", m_load_data, 32'd0);
    check("rst_valid", {31'd0, m_load_valid}, 32'd0);
    check("rst_stall", {31'd0, m_stall}, 32'd0);
    reset = 1'b1;

    do_access(1'b1, 1'b0, 1'b0, 32'h0000_0100, 32'h0, 1, 32'hDEAD_BEEF);
    do_access(1'b1, 1'b0, 1'b1, 32'h0000_0103, 32'h0, 4, 32'hAABB_CCDD);
    do_access(1'b0, 1'b1, 1'b1, 32'h0000_0201, 32'h1234_5678, 2, 32'h0);
    do_access(1'b1, 1'b0, 1'b0, 32'h0000_0102, 32'h0, 1, 32'h0);
    do_access(1'b1, 1'b1, 1'b0, 32'h0000_0300, 32'h0000_0055, 3, 32'h0);

    for (int n = 0; n < 200; n++) begin
      logic rd, wr, bt;
      logic [31:0] a;
      rd = $urandom_range(0, 1);
      wr = $urandom_range(0, 1);
      if (!rd && !wr) rd = 1'b1;
      bt = $urandom_range(0, 1);
      a  = $urandom;
      if (!bt && $urandom_range(0, 3) != 0) a[1:0] = 2'b00;
      do_access(rd, wr, bt, a, $urandom, $urandom_range(1, 5), $urandom);
    end

    // Spurious ack while idle must be ignored.
    @(posedge clock); #1;
    mem_ack   = 1'b1;
    mem_rdata = 32'hFFFF_FFFF;
    @(negedge clock);
    check("idle_ack_req", {31'd0, mem_req}, 32'd0);
    check("idle_ack_valid", {31'd0, m_load_valid}, 32'd0);
    @(posedge clock); #1;
    mem_ack = 1'b0;
    @(negedge clock);
    check("idle_ack_valid2", {31'd0, m_load_valid}, 32'd0);
    check("idle_ack_data", m_load_data, model_load);

    // Reset asserted while a load is in REQ.
    @(posedge clock); #1;
    m_mem_read   = 1'b1;
    m_mem_byte   = 1'b0;
    m_alu_result = 32'h0000_0400;
    @(posedge clock); #1;
    @(negedge clock);
    check("pre_rst_req", {31'd0, mem_req}, 32'd1);
    #1;
    reset = 1'b0;
    #1;
    check("async_rst_req", {31'd0, mem_req}, 32'd0);
    check("async_rst_stall", {31'd0, m_stall}, 32'd0);
    check("async_rst_data", m_load_data, 32'd0);
    @(posedge clock); #1;
    drive_idle();
    reset      = 1'b1;
    model_load = 32'd0;
    mem_ack    = 1'b1;
    mem_rdata  = 32'h1357_9BDF;
    @(negedge clock);
    check("post_rst_req", {31'd0, mem_req}, 32'd0);
    check("post_rst_valid", {31'd0, m_load_valid}, 32'd0);
    @(posedge clock); #1;
    mem_ack = 1'b0;
    @(negedge clock);
    check("post_rst_valid2", {31'd0, m_load_valid}, 32'd0);
    check("post_rst_data", m_load_data, 32'd0);

    do_access(1'b1, 1'b0, 1'b1, 32'h0000_0502, 32'h0, 2, 32'h1122_3344);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fails);
    $finish;
  end

endmodule
